// File: rtl/alu_result_buffer_if.sv
// Producer/consumer bundle of the ALU result buffer: ALU result strobe in, show-ahead head and status out.
interface alu_result_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0]    i_data;
  logic                     i_overflow;
  logic                     i_valid;
  logic                     i_clr;
  logic                     i_ready;
  logic [DATA_WIDTH-1:0]    o_data;
  logic                     o_overflow;
  logic                     o_valid;
  logic                     o_full;
  logic                     o_empty;
  logic [$clog2(DEPTH):0]   o_count;
  logic                     o_drop;
  logic [CNT_WIDTH-1:0]     o_ovf_count;

  modport slave (
    input  i_data, i_overflow, i_valid, i_clr, i_ready,
    output o_data, o_overflow, o_valid, o_full, o_empty, o_count, o_drop, o_ovf_count
  );

  modport master (
    output i_data, i_overflow, i_valid, i_clr, i_ready,
    input  o_data, o_overflow, o_valid, o_full, o_empty, o_count, o_drop, o_ovf_count
  );
endinterface

// File: rtl/alu_result_buffer.sv
// Show-ahead capture FIFO behind the ALU: absorbs every result, drops on full, tracks
// occupancy, a sticky drop flag and a saturating count of accepted overflow results.
module alu_result_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  alu_result_buffer_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic                  overflow;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic                 drop_q;
  logic [CNT_WIDTH-1:0] ovf_cnt;

  logic   full_c;
  logic   empty_c;
  logic   pop_c;
  logic   push_c;
  logic   drop_c;
  entry_t head_c;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);

  // Clear wins over everything; a full buffer still accepts when the head leaves this cycle.
  assign pop_c  = !empty_c && bus.i_ready && !bus.i_clr;
  assign push_c = bus.i_valid && !bus.i_clr && (!full_c || pop_c);
  assign drop_c = bus.i_valid && !bus.i_clr && full_c && !pop_c;

  // Storage is never reset; emptiness gates what reaches the outputs.
  always_ff @(posedge i_clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{overflow: bus.i_overflow, data: bus.i_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      drop_q  <= 1'b0;
      ovf_cnt <= '0;
    end else if (bus.i_clr) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      drop_q  <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_c && !pop_c) begin
        count <= count + CW'(1);
      end else if (pop_c && !push_c) begin
        count <= count - CW'(1);
      end
      if (drop_c) begin
        drop_q <= 1'b1;
      end
      if (push_c && bus.i_overflow && (ovf_cnt != '1)) begin
        ovf_cnt <= ovf_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign head_c = mem[rd_ptr];

  assign bus.o_data      = empty_c ? '0 : head_c.data;
  assign bus.o_overflow  = empty_c ? 1'b0 : head_c.overflow;
  assign bus.o_valid     = !empty_c;
  assign bus.o_empty     = empty_c;
  assign bus.o_full      = full_c;
  assign bus.o_count     = count;
  assign bus.o_drop      = drop_q;
  assign bus.o_ovf_count = ovf_cnt;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: queue-based reference model checked every cycle,
// plus literal expectations along the directed scenarios.
module tb_alu_result_buffer;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNTW  = 4;

  logic i_clk;
  logic i_rst_n;
  int   n_tests;
  int   n_fails;

  alu_result_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) bus ();

  alu_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {overflow, data} plus status, updated from the rules directly.
  logic [DW:0] mq[$];
  logic        m_drop;
  int          m_ovf;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mq.delete();
      m_drop = 1'b0;
      m_ovf  = 0;
    end else if (bus.i_clr) begin
      mq.delete();
      m_drop = 1'b0;
      m_ovf  = 0;
    end else begin
      if (mq.size() > 0 && bus.i_ready) void'(mq.pop_front());
      if (bus.i_valid) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({bus.i_overflow, bus.i_data});
          if (bus.i_overflow && m_ovf < (2 ** CNTW) - 1) m_ovf = m_ovf + 1;
        end else begin
          m_drop = 1'b1;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      check("valid", 64'(bus.o_valid), 64'(mq.size() > 0));
      check("empty", 64'(bus.o_empty), 64'(mq.size() == 0));
      check("full", 64'(bus.o_full), 64'(mq.size() == DEPTH));
      check("count", 64'(bus.o_count), 64'(mq.size()));
      check("drop", 64'(bus.o_drop), 64'(m_drop));
      check("ovf_count", 64'(bus.o_ovf_count), 64'(m_ovf));
      if (mq.size() > 0) begin
        check("head_data", 64'(bus.o_data), 64'(mq[0][DW-1:0]));
        check("head_ovf", 64'(bus.o_overflow), 64'(mq[0][DW]));
      end
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ovf,
                     input logic rdy, input logic clr);
    bus.i_valid    = v;
    bus.i_data     = d;
    bus.i_overflow = ovf;
    bus.i_ready    = rdy;
    bus.i_clr      = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill_1_to_8();
    for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain_expect(input int first, input int last_val, input string tag);
    for (int i = first; i <= last_val; i++) begin
      check(tag, 64'(bus.o_data), 64'(i));
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fails = 0;
    i_rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_overflow = 1'b0;
    bus.i_ready = 1'b0; bus.i_clr = 1'b0;
    #23 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Reset then idle
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_empty", 64'(bus.o_empty), 64'd1);
    check("rst_count", 64'(bus.o_count), 64'd0);
    check("rst_drop", 64'(bus.o_drop), 64'd0);
    check("rst_ovf", 64'(bus.o_ovf_count), 64'd0);
    check("rst_data", 64'(bus.o_data), 64'd0);

    // Fill and drain
    fill_1_to_8();
    check("fill_full", 64'(bus.o_full), 64'd1);
    check("fill_count", 64'(bus.o_count), 64'd8);
    drain_expect(1, 8, "drain_data");
    check("drain_empty", 64'(bus.o_empty), 64'd1);

    // Drop on full
    fill_1_to_8();
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    check("dropfull_drop", 64'(bus.o_drop), 64'd1);
    check("dropfull_count", 64'(bus.o_count), 64'd8);
    drain_expect(1, 8, "dropfull_data");
    check("dropfull_empty", 64'(bus.o_empty), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("clr_drop", 64'(bus.o_drop), 64'd0);

    // Full with simultaneous push and pop
    fill_1_to_8();
    cyc(1'b1, 32'h9, 1'b0, 1'b1, 1'b0);
    check("pp_drop", 64'(bus.o_drop), 64'd0);
    check("pp_count", 64'(bus.o_count), 64'd8);
    drain_expect(2, 9, "pp_data");

    // Overflow counting, dropped overflow not counted, clear with push
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(32'h40 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, DW'(32'h50 + i), 1'b0, 1'b0, 1'b0);
    check("ovf_three", 64'(bus.o_ovf_count), 64'd3);
    check("ovf_head_flag", 64'(bus.o_overflow), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(32'h60 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h70, 1'b1, 1'b0, 1'b0);
    check("ovf_drop_uncounted", 64'(bus.o_ovf_count), 64'd3);
    check("ovf_drop_set", 64'(bus.o_drop), 64'd1);
    cyc(1'b1, 32'h80, 1'b1, 1'b1, 1'b1);
    check("clr_count", 64'(bus.o_count), 64'd0);
    check("clr_ovf", 64'(bus.o_ovf_count), 64'd0);
    check("clr_drop2", 64'(bus.o_drop), 64'd0);

    // Saturation of the overflow counter at 2^CNT_WIDTH-1
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(32'h200 + i), 1'b1, 1'b1, 1'b0);
    check("ovf_sat", 64'(bus.o_ovf_count), 64'd15);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Wrap-around at count 1
    cyc(1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      check("wrap_data", 64'(bus.o_data), 64'(100 + k - 1));
      cyc(1'b1, DW'(100 + k), 1'b0, 1'b1, 1'b0);
    end
    check("wrap_count", 64'(bus.o_count), 64'd1);

    // Async reset mid-stream at count 5
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(32'h300 + i), 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 64'(bus.o_count), 64'd5);
    bus.i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.o_valid), 64'd0);
    check("arst_count", 64'(bus.o_count), 64'd0);
    check("arst_empty", 64'(bus.o_empty), 64'd1);
    @(negedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    cyc(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
    check("post_rst_data", 64'(bus.o_data), 64'hA5);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("post_rst_empty", 64'(bus.o_empty), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end
endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Result capture FIFO sitting directly downstream of the 32-bit registered ALU. It absorbs every valid result the ALU emits, because the ALU has no backpressure. It presents results to the consumer through a show-ahead valid/ready interface. It also keeps status: occupancy, a sticky drop flag and a saturating count of overflowed results.

## Interface
- DATA_WIDTH, 32, result width; matches ALU output width
- DEPTH, 8, number of entries; power of two, minimum 2
- CNT_WIDTH, 16, width of the overflow-result counter
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_data  input  DATA_WIDTH  result from ALU o_data
- i_overflow  input  1  overflow flag from ALU o_overflow
- i_valid  input  1  result strobe from ALU o_valid; one result per asserted cycle
- i_clr  input  1  synchronous flush and status clear
- i_ready  input  1  consumer accepts head entry this cycle
- o_data  output  DATA_WIDTH  head entry data
- o_overflow  output  1  head entry overflow flag
- o_valid  output  1  head entry present (equals not o_empty)
- o_full  output  1  occupancy == DEPTH
- o_empty  output  1  occupancy == 0
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- o_drop  output  1  sticky; set when a result was discarded because the buffer was full
- o_ovf_count  output  CNT_WIDTH  saturating count of accepted entries with overflow=1

## Operation
- Storage: DEPTH entries of {overflow, data}; read and write pointers of $clog2(DEPTH) bits wrap modulo DEPTH; occupancy counter held separately.
- Push request: i_valid=1. Pop: o_valid && i_ready. i_ready while empty is ignored; no pop occurs and there is no underflow.
- Push accepted when not full, or when full and a pop occurs in the same cycle. Full with no pop: the result is discarded, o_drop is set to 1, and pointers, count and o_ovf_count are unchanged.
- Simultaneous accepted push and pop: both pointers advance and the count is unchanged.
- o_ovf_count increments by 1 on each accepted push with i_overflow=1. It holds at 2^CNT_WIDTH-1 and does not wrap. Dropped results are not counted.
- i_clr=1 takes priority over push and pop in the same cycle:
  - pointers and count go to 0, and o_drop and o_ovf_count go to 0;
  - the concurrent push is discarded and does not set o_drop;
  - no pop handshake completes.
- Output order is strict FIFO. Data and flag are never modified while stored.

## Timing
- Reset (async assert, sync to clock after deassert): pointers=0, count=0, o_empty=1, o_full=0, o_valid=0, o_drop=0, o_ovf_count=0, o_data=0, o_overflow=0. Storage contents need no reset.
- Write latency: an entry pushed at edge N is visible on o_data/o_valid after edge N. The block is show-ahead, and head data is driven from storage at the read pointer. There is no same-cycle bypass from i_data to o_data.
- Pop: the head is consumed at the edge where o_valid && i_ready. The next entry (if any) appears after that edge.
- Drain throughput: one entry per cycle with i_ready held high. Fill throughput: one entry per cycle.
- o_full, o_empty and o_count are derived from the registered count only. They reflect the state after the last edge and carry no combinational dependence on i_valid, i_ready or i_clr.
- o_data/o_overflow when empty: must not be X after reset. No value is guaranteed otherwise.
- Reset mid-operation: all contents are lost immediately and status returns to reset values.

## Test plan
- Reset then idle: after i_rst_n low→high, o_valid=0, o_empty=1, o_count=0, o_drop=0, o_ovf_count=0.
- Fill and drain: push 8 results 0x1..0x8 with i_ready=0, so o_full=1 and o_count=8. Then hold i_ready=1 with no pushes. o_data must show 0x1..0x8 on consecutive cycles, then o_empty=1.
- Drop on full: with the buffer full, push 0xDEAD with i_ready=0. Required: o_drop=1, o_count=8, and a subsequent drain yields 0x1..0x8 with no 0xDEAD.
- Full with simultaneous push/pop: with the buffer full and i_ready=1, push 0x9. Required: o_drop stays 0, o_count stays 8, and 0x9 emerges after 0x2..0x8.
- Overflow counting and clear:
  - Push 3 results with i_overflow=1 and 2 with i_overflow=0; o_ovf_count=3.
  - Assert i_clr together with a push: o_count=0, o_ovf_count=0 and o_drop=0 on the next cycle.
- Wrap-around and async reset: push and pop 20 results continuously at count 1; order is preserved across the pointer wrap. Assert i_rst_n low mid-stream with count=5; o_valid drops to 0 without waiting for a clock edge.
